// File: rtl/fetch_pkg.sv
// Shared widths, queue entry type and FSM states for the instruction-fetch stage.
// The entry type is built from these widths, so change fetch widths here.
package fetch_pkg;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries feeding decode.
// Flush empties the buffer and takes priority over a simultaneous push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     entry_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues ROM reads and buffers words for decode.
// Optional FETCH_PERF_EN adds delivered-instruction and redirect counters.
module fetch_unit #(
  parameter int                ADDR_W     = fetch_pkg::ADDR_W,
  parameter int                INST_W     = fetch_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_en_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_data_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count_o,
  output logic [31:0]       redirect_count_o,
`endif
  output logic [ADDR_W-1:0] inst_pc_o
);

  import fetch_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = CNT_W + 1;

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              issue, pop, credit_ok;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      push_entry, head;

  assign inst_valid_o = (fifo_count != '0);
  assign pop          = inst_valid_o && inst_ready_i;

  // Buffered plus in-flight words must leave room for the read being issued now.
  assign credit_ok = (CRED_W'(fifo_count) + CRED_W'(inflight_q))
                   < (CRED_W'(FIFO_DEPTH) + CRED_W'(pop));
  assign issue     = (state_q == RUN) && !redirect_valid_i && credit_ok;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)
      pc_d = redirect_pc_i & ~ADDR_W'(INST_BYTES - 1);
    else if (issue)
      pc_d = pc_q + ADDR_W'(INST_BYTES);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= HALT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      case (state_q)
        HALT:    if (fetch_en_i)  state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= HALT;
        default: state_q <= HALT;
      endcase
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, inst: rom_data_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .entry_i (push_entry),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign rom_en_o    = issue;
  assign rom_addr_o  = pc_q;
  assign inst_data_o = head.inst;
  assign inst_pc_o   = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, redirect_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      if (pop)              fetch_count_q    <= fetch_count_q + 32'd1;
      if (redirect_valid_i) redirect_count_q <= redirect_count_q + 32'd1;
    end
  end

  assign fetch_count_o    = fetch_count_q;
  assign redirect_count_o = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle-latency ROM returning addr^'hA5.
// Inputs change and outputs are checked just after the falling clock edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEn;
  logic        romEn;
  logic [31:0] romAddr;
  logic [31:0] romData = '0;
  logic        redirValid;
  logic [31:0] redirPc;
  logic        instValid;
  logic        instReady;
  logic [31:0] instData;
  logic [31:0] instPc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] redirectCount;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_en_i       (fetchEn),
    .rom_en_o         (romEn),
    .rom_addr_o       (romAddr),
    .rom_data_i       (romData),
    .redirect_valid_i (redirValid),
    .redirect_pc_i    (redirPc),
    .inst_valid_o     (instValid),
    .inst_ready_i     (instReady),
    .inst_data_o      (instData),
`ifdef FETCH_PERF_EN
    .fetch_count_o    (fetchCount),
    .redirect_count_o (redirectCount),
`endif
    .inst_pc_o        (instPc)
  );

  // ROM model: one cycle read latency, contents are the address XOR 'hA5.
  always_ff @(posedge clk) begin
    if (romEn) romData <= romAddr ^ 32'h0000_00A5;
  end

  task automatic applyStimulus(input logic rstVal, input logic enVal, input logic readyVal,
                               input logic redirVal, input logic [31:0] pcVal);
    rst        = rstVal;
    fetchEn    = enVal;
    instReady  = readyVal;
    redirValid = redirVal;
    redirPc    = pcVal;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "Valid"}, instValid, 1'b1);
    checkOutput({tag, "Pc"}, instPc, pc);
    checkOutput({tag, "Data"}, instData, pc ^ 32'h0000_00A5);
  endtask

  // Collects n deliveries in PC order starting this cycle; ready is assumed held high.
  task automatic collectStream(input int n, input logic [31:0] startPc);
    logic [31:0] expPc;
    int got;
    expPc = startPc;
    got   = 0;
    for (int cyc = 0; cyc < 3 * n + 10; cyc++) begin
      #1;
      if (instValid === 1'b1) begin
        checkOutput("streamPc", instPc, expPc);
        checkOutput("streamData", instData, expPc ^ 32'h0000_00A5);
        expPc = expPc + 32'd4;
        got++;
      end
      if (got == n) break;
      @(negedge clk);
    end
    checkOutput("streamCount", got, n);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("rstRomEn", romEn, 1'b0);
    checkOutput("rstValid", instValid, 1'b0);
    checkOutput("rstData", instData, 32'h0);
    checkOutput("rstPc", instPc, 32'h0);
    checkOutput("rstAddr", romAddr, 32'h0);

    // Sequential streaming at one instruction per cycle.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checkOutput("seqRomEn", romEn, 1'b1);
      checkOutput("seqAddr", romAddr, 32'(4 * i));
      if (i >= 2) checkHead("seq", 32'(4 * (i - 2)));
      else checkOutput("seqEarlyValid", instValid, 1'b0);
    end

    // Back-pressure: issue stops once the buffer and in-flight read fill it.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput("stallRomEn", romEn, 1'b0);
      checkHead("stall", 32'h18);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    collectStream(4, 32'h18);

    // Redirect with a read in flight; head popped this cycle still delivered.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    #1;
    checkOutput("redirRomEn", romEn, 1'b0);
    checkHead("redirPop", 32'h28);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("redirT1Valid", instValid, 1'b0);
    checkOutput("redirT1RomEn", romEn, 1'b1);
    checkOutput("redirT1Addr", romAddr, 32'h100);
    @(negedge clk); #1;
    checkOutput("redirT2Valid", instValid, 1'b0);
    checkOutput("redirT2Addr", romAddr, 32'h104);
    @(negedge clk); #1;
    checkHead("redirT3", 32'h100);
    @(negedge clk); #1;
    checkHead("redirT4", 32'h104);

    // Unaligned redirect coinciding with a pop.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
    #1;
    checkOutput("alignRomEn", romEn, 1'b0);
    checkHead("alignPop", 32'h108);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("alignAddr", romAddr, 32'h100);
    checkOutput("alignRomEn2", romEn, 1'b1);
    checkOutput("alignValid", instValid, 1'b0);
    @(negedge clk); #1;
    checkOutput("alignValid2", instValid, 1'b0);
    @(negedge clk); #1;
    checkHead("alignHead", 32'h100);
`ifdef FETCH_PERF_EN
    checkOutput("perfFetchMid", fetchCount, 32'd14);
    checkOutput("perfRedirMid", redirectCount, 32'd2);
`endif

    // PC wrap at the top of the address space.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    #1;
    checkHead("wrapPop", 32'h104);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("wrapAddr0", romAddr, 32'hFFFF_FFFC);
    checkOutput("wrapValid0", instValid, 1'b0);
    @(negedge clk); #1;
    checkOutput("wrapAddr1", romAddr, 32'h0);
    checkOutput("wrapValid1", instValid, 1'b0);
    @(negedge clk); #1;
    checkHead("wrapHead0", 32'hFFFF_FFFC);
    @(negedge clk); #1;
    checkHead("wrapHead1", 32'h0);

    // Halt mid-stream: in-flight word still reaches decode.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkHead("haltT0", 32'h4);
    @(negedge clk); #1;
    checkOutput("haltRomEn1", romEn, 1'b0);
    checkHead("haltT1", 32'h8);
    @(negedge clk); #1;
    checkOutput("haltRomEn2", romEn, 1'b0);
    checkHead("haltInflight", 32'hC);
    @(negedge clk); #1;
    checkOutput("haltEmpty", instValid, 1'b0);
    checkOutput("haltRomEn3", romEn, 1'b0);
    checkOutput("haltAddr", romAddr, 32'h10);

    // Resume, then assert reset between clock edges with a read in flight.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("resumeRomEn", romEn, 1'b1);
    checkOutput("resumeAddr", romAddr, 32'h10);
    @(negedge clk);
    @(negedge clk); #1;
    checkHead("resumeHead", 32'h10);
`ifdef FETCH_PERF_EN
    checkOutput("perfFetchEnd", fetchCount, 32'd21);
    checkOutput("perfRedirEnd", redirectCount, 32'd3);
`endif
    #2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("asyncRomEn", romEn, 1'b0);
    checkOutput("asyncValid", instValid, 1'b0);
    checkOutput("asyncData", instData, 32'h0);
    checkOutput("asyncPc", instPc, 32'h0);
    checkOutput("asyncAddr", romAddr, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("asyncFetchCnt", fetchCount, 32'd0);
    checkOutput("asyncRedirCnt", redirectCount, 32'd0);
`endif
    @(negedge clk); #1;
    checkOutput("heldValid", instValid, 1'b0);
    checkOutput("heldRomEn", romEn, 1'b0);

    // Restart from RESET_PC after reset; the dropped in-flight word must not appear.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("restartAddr0", romAddr, 32'h0);
    checkOutput("restartRomEn", romEn, 1'b1);
    checkOutput("restartValid", instValid, 1'b0);
    @(negedge clk); #1;
    checkOutput("restartAddr1", romAddr, 32'h4);
    checkOutput("restartValid1", instValid, 1'b0);
    @(negedge clk); #1;
    checkHead("restartHead", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
